// File: rtl/debounce_pulse.sv
// rtl/debounce_pulse.sv - push-button synchronizer, debouncer and one-clock press pulse generator.
// Define AUTOREPEAT_EN to emit a pulse every REPEAT_CYCLES clocks while the button stays pressed.
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic enable_out,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("debounce_pulse: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    state_t          state_q, state_d;
    logic            s1_q, s2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            en_q, en_d;
    logic            lvl_q, lvl_d;

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]   rpt_q, rpt_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        lvl_d   = lvl_q;
        case (state_q)
            RELEASED: begin
                if (s2_q) state_d = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!s2_q) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    en_d    = 1'b1;
                    lvl_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!s2_q) state_d = RELEASE_CHK;
            end
            RELEASE_CHK: begin
                if (s2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    lvl_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RELEASED;
        endcase
        // Every state change restarts the stability count for the next candidate level.
        if (state_d != state_q) cnt_d = '0;

`ifdef AUTOREPEAT_EN
        rpt_d = rpt_q;
        if (state_q == PRESSED && state_d == PRESSED) begin
            if (rpt_q == RPT_LAST) begin
                en_d  = 1'b1;
                rpt_d = '0;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end else if (state_d == PRESSED) begin
            rpt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            lvl_q   <= 1'b0;
`ifdef AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            lvl_q   <= lvl_d;
`ifdef AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign enable_out = en_q;
    assign btn_level  = lvl_q;

endmodule

// File: doc/debounce_pulse.md
# debounce_pulse

Upstream conditioning stage for the 4-bit counter. Takes a raw, asynchronous, bouncing push-button level and produces a clean one-clock `enable_out` pulse per press, which drives the counter's `enable` input. Also exports the debounced button level. It contains a 2-flop synchronizer, a debounce counter and a 4-state FSM.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a level change. Legal values are 2 or more.
- `REPEAT_CYCLES`, default 64: autorepeat period in clocks. Used only with `AUTOREPEAT_EN`. Legal values are 2 or more.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `btn_in`  input  1  raw button level, asynchronous to `clk`; 1 = pressed.
- `enable_out`  output  1  registered one-cycle pulse per accepted press; connect to the counter's `enable`.
- `btn_level`  output  1  registered debounced button level.

## Operation
- **Synchronizer:** `btn_in` feeds two flops, `s1` then `s2`. The FSM only ever sees `s2`. The raw input is never used elsewhere.
- **Debounce counter `cnt`:** width is `$clog2(DEBOUNCE_CYCLES)`+1. It is cleared on every FSM state change. It increments by 1 per cycle in the CHK states while `s2` matches the candidate level.
- **FSM states and transitions:**
  - **RELEASED**: if `s2`=1, go to PRESS_CHK.
  - **PRESS_CHK**:
    - if `s2`=0, return to RELEASED (bounce rejected, no output);
    - if `s2`=1 and `cnt`==`DEBOUNCE_CYCLES`-1, go to PRESSED, assert `enable_out` for that one cycle, and set `btn_level`=1;
    - otherwise increment `cnt`.
  - **PRESSED**: if `s2`=0, go to RELEASE_CHK.
  - **RELEASE_CHK**:
    - if `s2`=1, return to PRESSED with no pulse;
    - if `s2`=0 and `cnt`==`DEBOUNCE_CYCLES`-1, go to RELEASED and clear `btn_level`;
    - otherwise increment `cnt`.
- **`enable_out`:**
  - Deasserts the cycle after it is asserted.
  - Never high for two consecutive cycles.
  - Never asserted on release.
- **`btn_level`:** changes only on PRESS_CHK→PRESSED or RELEASE_CHK→RELEASED.
- **Reset (`reset`=0, any time):**
  - `s1`, `s2`, `cnt` and the repeat counter go to 0; state goes to RELEASED; `enable_out`=0; `btn_level`=0.
  - A debounce in progress is discarded.
  - After `reset` rises with `btn_in` held at 1, a full debounce sequence is required before the pulse.

## Timing
- Edge e0 is the first rising edge after `btn_in` becomes stably 1.
  - `s2`=1 after e1.
  - State is PRESS_CHK after e2.
  - `enable_out` and `btn_level` rise at edge e(`DEBOUNCE_CYCLES`+2). This is `DEBOUNCE_CYCLES`+3 edges counting e0.
  - `enable_out` falls one edge later.
- Release latency is identical: `btn_level` falls `DEBOUNCE_CYCLES`+3 edges after `btn_in` is stably 0.
- Any input glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- The counter downstream samples `enable_out` on the next rising edge, so exactly one count per press.

## Configuration
- Macro: `AUTOREPEAT_EN`.
- **Defined:**
  - A repeat counter is cleared on entry to PRESSED and increments each cycle in PRESSED.
  - When it reaches `REPEAT_CYCLES`-1, `enable_out` pulses one cycle and the counter clears.
  - Result: pulses every `REPEAT_CYCLES` clocks after the first pulse while the button stays pressed.
  - PRESSED→RELEASE_CHK freezes the repeat counter. RELEASE_CHK→PRESSED clears it without a pulse.
- **Undefined:**
  - The repeat counter is not built and `REPEAT_CYCLES` is ignored.
  - Exactly one pulse per accepted press.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=8, 10 ns clock, and drive `btn_in` at negedge.
- **Reset hold:** `reset`=0 for 5 cycles with `btn_in`=1 -> `enable_out`=0 and `btn_level`=0 throughout. After `reset`=1, exactly one pulse at edge 7 after release.
- **Clean press:** `btn_in` 0→1, held 20 cycles -> a single `enable_out` pulse at the 7th edge, and `btn_level`=1 from that same edge.
- **Bouncy press:** `btn_in` toggles every 2 cycles for 12 cycles, then holds 1 -> exactly one pulse, 7 edges after the final rise.
- **Release and glitch:** from PRESSED, a 2-cycle low glitch -> `btn_level` stays 1 and no pulse. Then a stable 0 -> `btn_level` falls at the 7th edge with no pulse.
- **Reset mid-debounce:** `reset`=0 for 1 cycle while in PRESS_CHK with `cnt`=2 -> no pulse, and the count restarts from 0.
- **Autorepeat and system check:**
  - With `AUTOREPEAT_EN`, hold 30 cycles -> pulses at edges 7, 15 and 23. Without the macro -> a pulse at edge 7 only.
  - Chained to the counter, 5 presses -> `Q`=4'b0101.
